hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 110 +++++++++++
 tb/tb_hazard_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: RAW-hazard bubble insertion, taken-jump flush,
// external freeze, and saturating performance counters for stalls and flushes.
module hazard_ctrl #(
    parameter int unsigned EX_BUBBLES = 2,
    parameter int unsigned WB_BUBBLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  rs1_id,
    input  logic [5:0]  rs2_id,
    input  logic        rs1_used,
    input  logic        rs2_used,
    input  logic [5:0]  rd_ex,
    input  logic        regWrite_ex,
    input  logic [5:0]  rd_wb,
    input  logic        regWrite_wb,
    input  logic        jump_ex,
    input  logic        ext_stall,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        pipe_hold,
    output logic        state,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_cycles
);

    typedef enum logic {StRun, StStall} state_e;

    localparam logic [2:0] ExLoad = 3'(EX_BUBBLES - 1);
    localparam logic [2:0] WbLoad = 3'(WB_BUBBLES - 1);

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] stall_q, stall_d, flush_q, flush_d;
    logic        hit_ex, hit_wb;
    logic [15:0] stall_inc, flush_inc;

    assign hit_ex = regWrite_ex & ((rs1_used & (rs1_id == rd_ex)) |
                                   (rs2_used & (rs2_id == rd_ex)));
    assign hit_wb = regWrite_wb & ((rs1_used & (rs1_id == rd_wb)) |
                                   (rs2_used & (rs2_id == rd_wb)));

    assign stall_inc = (stall_q == 16'hFFFF) ? stall_q : stall_q + 16'd1;
    assign flush_inc = (flush_q == 16'hFFFF) ? flush_q : flush_q + 16'd1;

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_hold   = 1'b0;
        state_d     = state_q;
        cnt_d       = cnt_q;
        stall_d     = stall_q;
        flush_d     = flush_q;
        if (rst) begin
            // State is already forced by the async reset; outputs kill the pipe.
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (ext_stall) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            pipe_hold  = 1'b1;
        end else if (jump_ex) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            state_d     = StRun;
            cnt_d       = 3'd0;
            flush_d     = flush_inc;
        end else if (state_q == StStall) begin
            // Comparators are ignored here; the countdown alone ends the stall.
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            cnt_d       = (cnt_q == 3'd0) ? 3'd0 : cnt_q - 3'd1;
            if (cnt_q <= 3'd1) state_d = StRun;
            stall_d     = stall_inc;
        end else if (hit_ex || hit_wb) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            cnt_d       = hit_ex ? ExLoad : WbLoad;
            state_d     = (cnt_d != 3'd0) ? StStall : StRun;
            stall_d     = stall_inc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StRun;
            cnt_q   <= 3'd0;
            stall_q <= 16'd0;
            flush_q <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign state        = (state_q == StStall);
    assign stall_cycles = stall_q;
    assign flush_cycles = flush_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus random stimulus
// compared against a per-cycle behavioural model of remaining bubbles and counters.
module tb_hazard_ctrl;

    localparam int EX_B = 2;
    localparam int WB_B = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  rs1_id, rs2_id, rd_ex, rd_wb;
    logic        rs1_used, rs2_used, regWrite_ex, regWrite_wb, jump_ex, ext_stall;
    logic        pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold, state;
    logic [15:0] stall_cycles, flush_cycles;

    int n_checks = 0;
    int n_err    = 0;
    bit do_checks = 1'b1;

    // Model: bubbles still owed after this cycle, and plain integer counters.
    int m_rem = 0;
    int m_sc  = 0;
    int m_fc  = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(
        .EX_BUBBLES (EX_B),
        .WB_BUBBLES (WB_B)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rs1_id       (rs1_id),
        .rs2_id       (rs2_id),
        .rs1_used     (rs1_used),
        .rs2_used     (rs2_used),
        .rd_ex        (rd_ex),
        .regWrite_ex  (regWrite_ex),
        .rd_wb        (rd_wb),
        .regWrite_wb  (regWrite_wb),
        .jump_ex      (jump_ex),
        .ext_stall    (ext_stall),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .ifid_flush   (ifid_flush),
        .idex_bubble  (idex_bubble),
        .pipe_hold    (pipe_hold),
        .state        (state),
        .stall_cycles (stall_cycles),
        .flush_cycles (flush_cycles)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    task automatic clear_inputs();
        rs1_id = 0; rs2_id = 0; rs1_used = 0; rs2_used = 0;
        rd_ex = 0; regWrite_ex = 0; rd_wb = 0; regWrite_wb = 0;
        jump_ex = 0; ext_stall = 0;
    endtask

    // Compare outputs against the model for the current inputs, then advance the
    // model to what the next posedge will produce.
    task automatic eval_and_step();
        bit hex, hwb, ep, eiw, efl, ebu, eho;
        int n_rem, n_sc, n_fc;
        hex = regWrite_ex && ((rs1_used && rs1_id == rd_ex) || (rs2_used && rs2_id == rd_ex));
        hwb = regWrite_wb && ((rs1_used && rs1_id == rd_wb) || (rs2_used && rs2_id == rd_wb));
        n_rem = m_rem; n_sc = m_sc; n_fc = m_fc;
        {ep, eiw, efl, ebu, eho} = 5'b11000;
        if (rst) begin
            m_rem = 0; m_sc = 0; m_fc = 0;
            n_rem = 0; n_sc = 0; n_fc = 0;
            {ep, eiw, efl, ebu, eho} = 5'b00110;
        end else if (ext_stall) begin
            {ep, eiw, efl, ebu, eho} = 5'b00001;
        end else if (jump_ex) begin
            {ep, eiw, efl, ebu, eho} = 5'b11110;
            n_rem = 0;
            n_fc  = sat_inc(m_fc);
        end else if (m_rem > 0) begin
            {ep, eiw, efl, ebu, eho} = 5'b00010;
            n_rem = m_rem - 1;
            n_sc  = sat_inc(m_sc);
        end else if (hex || hwb) begin
            {ep, eiw, efl, ebu, eho} = 5'b00010;
            n_rem = hex ? EX_B - 1 : WB_B - 1;
            n_sc  = sat_inc(m_sc);
        end
        if (do_checks) begin
            check_eq("pc_write",     32'(pc_write),     32'(ep));
            check_eq("ifid_write",   32'(ifid_write),   32'(eiw));
            check_eq("ifid_flush",   32'(ifid_flush),   32'(efl));
            check_eq("idex_bubble",  32'(idex_bubble),  32'(ebu));
            check_eq("pipe_hold",    32'(pipe_hold),    32'(eho));
            check_eq("state",        32'(state),        32'(m_rem > 0));
            check_eq("stall_cycles", 32'(stall_cycles), 32'(m_sc));
            check_eq("flush_cycles", 32'(flush_cycles), 32'(m_fc));
        end
        m_rem = n_rem; m_sc = n_sc; m_fc = n_fc;
    endtask

    task automatic cycle();
        @(negedge clk);
        eval_and_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex_hit();
        clear_inputs();
        rs1_id = 6'd5; rs1_used = 1'b1; rd_ex = 6'd5; regWrite_ex = 1'b1;
    endtask

    initial begin
        int fc0, sc0;
        clear_inputs();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;

        // EX hit: two bubbles, one STALL cycle.
        set_ex_hit();
        #1;
        check_eq("ex_hit_bubble", 32'(idex_bubble), 32'd1);
        cycle();
        check_eq("ex_hit_state", 32'(state), 32'd1);
        cycle();
        check_eq("ex_hit_back_run", 32'(state), 32'd0);
        clear_inputs();
        #1;
        check_eq("ex_hit_resume", 32'(pc_write), 32'd1);
        check_eq("ex_hit_count", 32'(stall_cycles), 32'd2);
        cycle();

        // WB hit, then the same with the source unused.
        clear_inputs();
        rs2_id = 6'd9; rs2_used = 1'b1; rd_wb = 6'd9; regWrite_wb = 1'b1;
        #1;
        check_eq("wb_hit_bubble", 32'(idex_bubble), 32'd1);
        cycle();
        check_eq("wb_hit_state", 32'(state), 32'd0);
        rs2_used = 1'b0;
        #1;
        check_eq("wb_unused_bubble", 32'(idex_bubble), 32'd0);
        check_eq("wb_unused_pc", 32'(pc_write), 32'd1);
        cycle();

        // Jump arriving in STALL.
        set_ex_hit();
        cycle();
        check_eq("pre_jump_state", 32'(state), 32'd1);
        clear_inputs();
        jump_ex = 1'b1;
        fc0 = m_fc;
        #1;
        check_eq("jump_flush", 32'(ifid_flush), 32'd1);
        check_eq("jump_pc", 32'(pc_write), 32'd1);
        cycle();
        check_eq("jump_state", 32'(state), 32'd0);
        check_eq("jump_fc", 32'(flush_cycles), 32'(fc0 + 1));
        jump_ex = 1'b0;
        #1;
        check_eq("jump_stall_ended", 32'(pc_write), 32'd1);
        cycle();

        // ext_stall wins over jump for three cycles, then the flush lands.
        ext_stall = 1'b1; jump_ex = 1'b1;
        fc0 = m_fc; sc0 = m_sc;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq("hold_pipe", 32'(pipe_hold), 32'd1);
            check_eq("hold_noflush", 32'(ifid_flush), 32'd0);
            cycle();
            check_eq("hold_fc", 32'(flush_cycles), 32'(fc0));
            check_eq("hold_sc", 32'(stall_cycles), 32'(sc0));
        end
        ext_stall = 1'b0;
        #1;
        check_eq("hold_release_flush", 32'(ifid_flush), 32'd1);
        cycle();
        clear_inputs();

        // Reset pulse in the middle of a STALL cycle.
        set_ex_hit();
        cycle();
        check_eq("pre_rst_state", 32'(state), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        m_rem = 0; m_sc = 0; m_fc = 0;
        check_eq("rst_state", 32'(state), 32'd0);
        check_eq("rst_sc", 32'(stall_cycles), 32'd0);
        check_eq("rst_fc", 32'(flush_cycles), 32'd0);
        check_eq("rst_pc", 32'(pc_write), 32'd0);
        check_eq("rst_ifw", 32'(ifid_write), 32'd0);
        check_eq("rst_flush", 32'(ifid_flush), 32'd1);
        check_eq("rst_bubble", 32'(idex_bubble), 32'd1);
        check_eq("rst_hold", 32'(pipe_hold), 32'd0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        clear_inputs();
        @(posedge clk);
        #1;
        cycle();

        // Saturation of stall_cycles.
        set_ex_hit();
        do_checks = 1'b0;
        for (int i = 0; i < 70000; i++) cycle();
        do_checks = 1'b1;
        check_eq("sat_sc", 32'(stall_cycles), 32'hFFFF);
        cycle();
        check_eq("sat_hold", 32'(stall_cycles), 32'hFFFF);

        // Random stimulus against the model.
        rst = 1'b1;
        clear_inputs();
        cycle();
        rst = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            rs1_id      = 6'($urandom_range(0, 3));
            rs2_id      = 6'($urandom_range(0, 3));
            rd_ex       = 6'($urandom_range(0, 3));
            rd_wb       = 6'($urandom_range(0, 3));
            rs1_used    = 1'($urandom_range(0, 1));
            rs2_used    = 1'($urandom_range(0, 1));
            regWrite_ex = ($urandom_range(0, 2) != 0);
            regWrite_wb = ($urandom_range(0, 2) != 0);
            jump_ex     = ($urandom_range(0, 9) == 0);
            ext_stall   = ($urandom_range(0, 7) == 0);
            rst         = ($urandom_range(0, 199) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
